// File: rtl/riscv_tb_pkg.sv
// Shared loader constants: state encodings, default widths and the NOP word.
package riscv_tb_pkg;

    localparam logic [2:0] LDR_IDLE    = 3'd0;
    localparam logic [2:0] LDR_LOAD    = 3'd1;
    localparam logic [2:0] LDR_HOLD    = 3'd2;
    localparam logic [2:0] LDR_RUN     = 3'd3;
    localparam logic [2:0] LDR_ERRWAIT = 3'd4;
    localparam logic [2:0] LDR_ERROR   = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE    = LDR_IDLE,
        S_LOAD    = LDR_LOAD,
        S_HOLD    = LDR_HOLD,
        S_RUN     = LDR_RUN,
        S_ERRWAIT = LDR_ERRWAIT,
        S_ERROR   = LDR_ERROR
    } ldr_state_e;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 32;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

endpackage

// File: rtl/release_timer.sv
// Load-and-count-down timer; done is high once the count reaches zero.
module release_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    // Reload on request, otherwise count down to zero while enabled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/program_loader.sv
// Streams a program into instruction memory, then releases the core from reset.
// Optional running checksum of written words: define PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
    import riscv_tb_pkg::*;
#(
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int DATA_W        = DEF_DATA_W,
    parameter int RELEASE_DELAY = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              overflow_err,
    output logic [ADDR_W:0]   word_count,
    output logic [31:0]       checksum
);

    localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

    ldr_state_e        state, state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic              hs, full, wr, clr, hold_enter, timer_done;

    // Outputs are pure decodes of the registered state, never of s_valid.
    assign s_ready   = (state == S_LOAD) || (state == S_ERRWAIT);
    assign cpu_reset = (state != S_RUN);
    assign load_done = (state == S_RUN);

    assign hs         = s_valid & s_ready;
    assign full       = (word_count == CAPACITY);
    assign wr         = hs && (state == S_LOAD) && !full;
    assign hold_enter = wr && s_last;
    assign clr        = start && (state == S_IDLE || state == S_RUN || state == S_ERROR);

    release_timer #(.W(4)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (hold_enter),
        .en       (state == S_HOLD),
        .load_val (4'(RELEASE_DELAY)),
        .done     (timer_done)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state decode; a full memory diverts the stream to the error path.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_LOAD;
            S_LOAD: begin
                if (hs) begin
                    if (full)        state_nxt = s_last ? S_ERROR : S_ERRWAIT;
                    else if (s_last) state_nxt = S_HOLD;
                end
            end
            S_HOLD:    if (timer_done) state_nxt = S_RUN;
            S_RUN:     if (start) state_nxt = S_LOAD;
            S_ERRWAIT: if (hs && s_last) state_nxt = S_ERROR;
            S_ERROR:   if (start) state_nxt = S_LOAD;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Write port, pointer, count and sticky overflow flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            ptr          <= '0;
            word_count   <= '0;
            overflow_err <= 1'b0;
        end else begin
            imem_we <= wr;
            if (wr) begin
                imem_addr  <= ptr;
                imem_wdata <= s_data;
                ptr        <= ptr + 1'b1;
                word_count <= word_count + 1'b1;
            end
            if (clr) begin
                ptr          <= '0;
                word_count   <= '0;
                overflow_err <= 1'b0;
            end else if (hs && state == S_LOAD && full) begin
                overflow_err <= 1'b1;
            end
        end
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [31:0] csum;

    // Running sum of the words actually written in this load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            csum <= '0;
        else if (clr)
            csum <= '0;
        else if (wr)
            csum <= csum + 32'(s_data);
    end

    assign checksum = csum;
`else
    assign checksum = 32'd0;
`endif

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Streams a program into the processor's instruction memory over a valid/ready interface, then releases the core from reset.
- Sits directly upstream of single_cycle_processor, driving its reset input and the instruction-memory write port. It replaces hierarchical pokes of instr_mem.
- Gives benches and boot logic one deterministic load-then-run sequence.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; capacity is 2^ADDR_W words.
- DATA_W, 32, instruction word width.
- RELEASE_DELAY, 2, clk edges cpu_reset stays high after the last write; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a load (also a reload from RUN).
- s_valid  in  1  upstream word valid.
- s_ready  out  1  loader accepts a word this cycle.
- s_data  in  DATA_W  instruction word.
- s_last  in  1  marks the final word of the program.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  ADDR_W  word address of the write.
- imem_wdata  out  DATA_W  write data.
- cpu_reset  out  1  active-high reset to the processor.
- load_done  out  1  high while the core runs a loaded program.
- overflow_err  out  1  sticky; program exceeded capacity.
- word_count  out  ADDR_W+1  words written in the current load.
- checksum  out  32  running checksum (see Optional Feature).

Behaviour:
- Reset (reset_n low, async): FSM=IDLE. cpu_reset=1. All other outputs 0. Address pointer and word_count cleared. A reset mid-load abandons the load; memory contents already written are not cleared.
- A handshake is s_valid & s_ready on a rising clk edge. s_ready is a registered state decode, never combinational on s_valid.
- IDLE: s_ready=0, cpu_reset=1. start -> LOAD; pointer, word_count, checksum and overflow_err are cleared on that edge.
- LOAD: s_ready=1, cpu_reset=1.
  - Each handshake registers imem_we=1, imem_addr=pointer, imem_wdata=s_data for exactly the following cycle. Write latency is 1 cycle.
  - On the same edge, pointer+1 and word_count+1.
  - A handshake with s_last -> HOLD.
  - A handshake while word_count==2^ADDR_W does not write. It sets overflow_err and goes to ERROR (or to ERRWAIT if the beat was not s_last).
  - start is ignored in LOAD.
- HOLD: s_ready=0, cpu_reset=1. A 4-bit counter counts RELEASE_DELAY edges, then -> RUN. cpu_reset falls on the edge entering RUN, i.e. RELEASE_DELAY+1 edges after the s_last handshake. The final imem write always completes before release.
- RUN: cpu_reset=0, load_done=1, s_ready=0.
  - start -> LOAD; cpu_reset rises and load_done falls on that same edge.
  - imem_we is never asserted in RUN.
- ERRWAIT: s_ready=1 and incoming words are sunk without writes until the s_last handshake -> ERROR.
- ERROR: cpu_reset=1, load_done=0, overflow_err=1. start -> LOAD and clears overflow_err.
- Zero-length program: not representable; s_last on the first beat loads one word.
- Pointer wrap: the pointer is ADDR_W bits wide and word_count is ADDR_W+1 bits, so a full memory is detected without the pointer wrapping.
- s_valid/s_data/s_last are don't-care outside LOAD/ERRWAIT.

Optional Feature:
- PROGRAM_LOADER_CHECKSUM_EN defined: checksum is the mod-2^32 sum of all words written in the current load (zero-extended if DATA_W<32). It updates on the same edge as word_count, is cleared on start, and is held in HOLD/RUN/ERROR. Overflowed or sunk words are excluded.
- Not defined: checksum is tied to 0 and no adder is inferred.

Decomposition:
- Shared package riscv_tb_pkg holds:
  - state encoding constants: LDR_IDLE=0, LDR_LOAD=1, LDR_HOLD=2, LDR_RUN=3, LDR_ERRWAIT=4, LDR_ERROR=5, in 3 bits;
  - the default ADDR_W/DATA_W constants;
  - the NOP word 32'h00000013.
- One natural sub-module: release_timer, a load-and-count-down counter with a done flag, used by HOLD.

Test Plan:
- Single word: start, then 32'h00628333 with s_last -> one-cycle imem_we at addr 0 with that data. cpu_reset falls 3 edges after the handshake; load_done=1; word_count=1; checksum=32'h00628333 (with CHECKSUM_EN).
- Three words 32'h00500293, 32'h00600313, 32'h00628333 with s_valid gapped by one idle cycle -> writes at addrs 0,1,2 in order. word_count=3. Core executes them: after 3 further cycles x6 reads 0xB.
- Overflow with ADDR_W=2: 5 words, s_last on the fifth -> addrs 0..3 written, fifth dropped. overflow_err=1, cpu_reset stays 1, state ERROR. A later start clears overflow_err.
- Reload from RUN: start pulse -> cpu_reset rises on the same edge. New word 32'h00073A03 overwrites addr 0; word_count and checksum restart from that word.
- Async reset: reset_n low mid-LOAD after 2 of 4 words -> outputs return to reset values immediately (cpu_reset=1, s_ready=0) with no clk edge. After release, state is IDLE and word_count=0.
- Backpressure: s_valid held high in IDLE and HOLD -> s_ready=0 and no writes. The beat is accepted on the first cycle of LOAD.
